// File: rtl/pattern_loader_pkg.sv
// Shared sizing constants, FSM encoding and frame-position helper for pattern_loader.
package pattern_loader_pkg;

    localparam int BYTES_PER_MEM = 7;
    localparam int NUM_MEMS      = 6;
    localparam int FRAME_BYTES   = 42;
    localparam int MEM_W         = 56;
    localparam int IDX_W         = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    // True when (word, slot) addresses the final byte of a frame.
    function automatic logic is_last_byte(input logic [IDX_W-1:0] mem_idx,
                                          input logic [IDX_W-1:0] byte_idx);
        return (int'(mem_idx) * BYTES_PER_MEM + int'(byte_idx)) == (FRAME_BYTES - 1);
    endfunction

endpackage

// File: rtl/pattern_loader.sv
// Assembles a 42-byte stream into six 56-bit words and commits them atomically.
// Optional trailing XOR checksum byte enabled by PATTERN_LOADER_CHECKSUM_EN.
module pattern_loader
    import pattern_loader_pkg::*;
#(
    parameter int ENABLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             byte_sof,
    output logic             byte_ready,
    output logic [MEM_W-1:0] linear_mem1,
    output logic [MEM_W-1:0] linear_mem2,
    output logic [MEM_W-1:0] linear_mem3,
    output logic [MEM_W-1:0] linear_mem4,
    output logic [MEM_W-1:0] linear_mem5,
    output logic [MEM_W-1:0] linear_mem6,
    output logic             data_enable,
    output logic             loading,
    output logic             frame_error,
    output state_e           state_dbg
);

    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
    // the source holds byte_in/byte_sof/byte_valid stable until that edge.

    localparam logic [5:0] EN_LOAD = 6'(ENABLE_CYCLES);

    state_e state_q, state_d;

    logic [IDX_W-1:0] mem_idx_q, mem_idx_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [7:0]       shadow_q [NUM_MEMS][BYTES_PER_MEM];
    logic [7:0]       shadow_d [NUM_MEMS][BYTES_PER_MEM];
    logic [MEM_W-1:0] lin_q [NUM_MEMS];
    logic [MEM_W-1:0] lin_d [NUM_MEMS];
    logic [5:0]       en_cnt_q, en_cnt_d;

    logic             accept;
    logic             last_byte;
    logic             restart;
    logic             store;
    logic [IDX_W-1:0] wr_mem;
    logic [IDX_W-1:0] wr_byte;

    assign accept    = byte_valid && byte_ready;
    assign last_byte = is_last_byte(mem_idx_q, byte_idx_q);
    // Byte 0 of a frame: any byte taken in IDLE, or a resync byte.
    assign restart   = (state_q == ST_IDLE) || byte_sof;
    assign store     = accept && ((state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                                  ((state_q == ST_CHECK) && byte_sof));
    assign wr_mem    = restart ? '0 : mem_idx_q;
    assign wr_byte   = restart ? '0 : byte_idx_q;

`ifdef PATTERN_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       err_q, err_d;
    logic       csum_ok;

    assign csum_ok = (byte_in == csum_q);
`endif

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (accept && !byte_sof && last_byte) begin
`ifdef PATTERN_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_COMMIT;
`endif
                end
            end
            ST_CHECK: begin
`ifdef PATTERN_LOADER_CHECKSUM_EN
                if (accept) begin
                    if (byte_sof)     state_d = ST_LOAD;
                    else if (csum_ok) state_d = ST_COMMIT;
                    else              state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        byte_ready = 1'b0;
        loading    = 1'b0;
        case (state_q)
            ST_IDLE:   byte_ready = !reset;
            ST_LOAD:   begin byte_ready = !reset; loading = 1'b1; end
            ST_CHECK:  begin byte_ready = !reset; loading = 1'b1; end
            ST_COMMIT: loading = 1'b1;
            default:   ;
        endcase
    end

    assign state_dbg = state_q;

    always_comb begin
        shadow_d   = shadow_q;
        lin_d      = lin_q;
        mem_idx_d  = mem_idx_q;
        byte_idx_d = byte_idx_q;
        en_cnt_d   = (en_cnt_q != '0) ? en_cnt_q - 6'd1 : '0;
        if (store) begin
            shadow_d[wr_mem][wr_byte] = byte_in;
            if (!restart && last_byte) begin
                mem_idx_d  = '0;
                byte_idx_d = '0;
            end else if (wr_byte == IDX_W'(BYTES_PER_MEM - 1)) begin
                byte_idx_d = '0;
                mem_idx_d  = wr_mem + 3'd1;
            end else begin
                byte_idx_d = wr_byte + 3'd1;
                mem_idx_d  = wr_mem;
            end
        end
        // Slot 0 of each word lands in the most significant byte.
        if (state_q == ST_COMMIT) begin
            for (int m = 0; m < NUM_MEMS; m++) begin
                for (int k = 0; k < BYTES_PER_MEM; k++) begin
                    lin_d[m][MEM_W-1-8*k -: 8] = shadow_q[m][k];
                end
            end
            en_cnt_d = EN_LOAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q   <= '{default: '{default: '0}};
            lin_q      <= '{default: '0};
            mem_idx_q  <= '0;
            byte_idx_q <= '0;
            en_cnt_q   <= '0;
        end else begin
            shadow_q   <= shadow_d;
            lin_q      <= lin_d;
            mem_idx_q  <= mem_idx_d;
            byte_idx_q <= byte_idx_d;
            en_cnt_q   <= en_cnt_d;
        end
    end

`ifdef PATTERN_LOADER_CHECKSUM_EN
    always_comb begin
        csum_d = csum_q;
        err_d  = 1'b0;
        if (store) csum_d = restart ? byte_in : (csum_q ^ byte_in);
        if (accept && (state_q == ST_CHECK) && !byte_sof && !csum_ok) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            err_q  <= err_d;
        end
    end

    assign frame_error = err_q;
`else
    assign frame_error = 1'b0;
`endif

    assign data_enable = (en_cnt_q != '0);
    assign linear_mem1 = lin_q[0];
    assign linear_mem2 = lin_q[1];
    assign linear_mem3 = lin_q[2];
    assign linear_mem4 = lin_q[3];
    assign linear_mem5 = lin_q[4];
    assign linear_mem6 = lin_q[5];

endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader: one instance with ENABLE_CYCLES=1, one with 4.
module tb_pattern_loader;
    import pattern_loader_pkg::*;

    localparam int W = MEM_W * NUM_MEMS;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_sof;

    logic             byte_ready, data_enable, loading, frame_error;
    logic [MEM_W-1:0] lm1, lm2, lm3, lm4, lm5, lm6;
    state_e           st;

    logic             b_ready, b_de, b_loading, b_err;
    logic [MEM_W-1:0] b1, b2, b3, b4, b5, b6;
    state_e           b_st;

    logic [MEM_W-1:0] got_w [NUM_MEMS];
    assign got_w[0] = lm1;
    assign got_w[1] = lm2;
    assign got_w[2] = lm3;
    assign got_w[3] = lm4;
    assign got_w[4] = lm5;
    assign got_w[5] = lm6;

    pattern_loader #(.ENABLE_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_sof(byte_sof), .byte_ready(byte_ready),
        .linear_mem1(lm1), .linear_mem2(lm2), .linear_mem3(lm3),
        .linear_mem4(lm4), .linear_mem5(lm5), .linear_mem6(lm6),
        .data_enable(data_enable), .loading(loading), .frame_error(frame_error),
        .state_dbg(st)
    );

    pattern_loader #(.ENABLE_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_sof(byte_sof), .byte_ready(b_ready),
        .linear_mem1(b1), .linear_mem2(b2), .linear_mem3(b3),
        .linear_mem4(b4), .linear_mem5(b5), .linear_mem6(b6),
        .data_enable(b_de), .loading(b_loading), .frame_error(b_err),
        .state_dbg(b_st)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    logic [7:0]   frm [FRAME_BYTES];
    int pulses = 0, ready_low = 0, run1 = 0, run4 = 0;
    logic de_prev = 1'b0, de4_prev = 1'b0;

    function automatic logic [W-1:0] pack_frame();
        logic [W-1:0] r;
        r = '0;
        for (int m = 0; m < NUM_MEMS; m++)
            for (int k = 0; k < BYTES_PER_MEM; k++)
                r[MEM_W*m + (MEM_W-1-8*k) -: 8] = frm[m*BYTES_PER_MEM + k];
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            run1 = 0; run4 = 0; de_prev = 1'b0; de4_prev = 1'b0;
        end else begin
            if (!byte_ready) ready_low++;
            if (data_enable && !de_prev) begin
                pulses++;
                if (exp_q.size() == 0) check("unexpected_commit", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    for (int i = 0; i < NUM_MEMS; i++)
                        check($sformatf("sb_mem%0d", i+1), got_w[i], mon_e[MEM_W*i +: MEM_W]);
                    check("sb_b_mem1", b1, mon_e[0 +: MEM_W]);
                end
            end
            if (data_enable) run1++;
            else if (de_prev) begin check("de_len_1", run1, 1); run1 = 0; end
            if (b_de) run4++;
            else if (de4_prev) begin check("de_len_4", run4, 4); run4 = 0; end
            de_prev  = data_enable;
            de4_prev = b_de;
        end
    end

    // Driver tasks
    task automatic send_byte(input logic [7:0] b, input logic sof);
        int n;
        n = 0;
        byte_in = b; byte_valid = 1'b1; byte_sof = sof;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", n < 50, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0; byte_sof = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int gap);
        logic [7:0] x;
        x = '0;
        for (int b = 0; b < FRAME_BYTES; b++) begin
            send_byte(frm[b], b == 0);
            x ^= frm[b];
            if (gap > 0 && b < FRAME_BYTES-1) idle(gap);
        end
`ifdef PATTERN_LOADER_CHECKSUM_EN
        send_byte(x, 1'b0);
`endif
    endtask

    int p0, r0, c1, c4;

    initial begin
        reset = 1'b1; byte_valid = 1'b0; byte_sof = 1'b0; byte_in = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", byte_ready, 0);
        check("rst_de", data_enable, 0);
        check("rst_loading", loading, 0);
        check("rst_err", frame_error, 0);
        check("rst_mem1", lm1, 0);
        check("rst_state", st, ST_IDLE);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", byte_ready, 1);

        // Incrementing frame, continuous stream, latency check
        for (int i = 0; i < FRAME_BYTES; i++) frm[i] = 8'(i);
        exp_q.push_back(pack_frame());
        send_frame(0);
        check("t1_de_early", data_enable, 0);
        check("t1_ready_commit", byte_ready, 0);
        check("t1_loading_commit", loading, 1);
        byte_valid = 1'b0;
        @(negedge clk);
        check("t1_de", data_enable, 1);
        check("t1_mem1", lm1, 56'h00010203040506);
        check("t1_mem6", lm6, 56'h23242526272829);
        check("t1_loading_idle", loading, 0);
        check("t1_ready_idle", byte_ready, 1);
        @(negedge clk);
        check("t1_de_off", data_enable, 0);
        idle(6);

        // Same frame with valid toggling
        p0 = pulses;
        exp_q.push_back(pack_frame());
        send_frame(1);
        idle(8);
        check("t2_pulses", pulses - p0, 1);
        check("t2_mem1", lm1, 56'h00010203040506);

        // Resync mid-frame
        p0 = pulses;
        for (int i = 0; i < 20; i++) send_byte(8'h11, i == 0);
        frm[0] = 8'hAA;
        for (int i = 1; i < FRAME_BYTES; i++) frm[i] = 8'h55;
        exp_q.push_back(pack_frame());
        send_frame(0);
        idle(8);
        check("t3_pulses", pulses - p0, 1);
        check("t3_mem1", lm1, 56'hAA555555555555);
        check("t3_mem4", lm4, 56'h55555555555555);

        // Reset mid-frame
        for (int i = 0; i <= 30; i++) send_byte(8'(i + 8'h40), i == 0);
        reset = 1'b1; byte_valid = 1'b0; byte_sof = 1'b0;
        #1;
        check("t4_mem1", lm1, 0);
        check("t4_mem6", lm6, 0);
        check("t4_loading", loading, 0);
        check("t4_ready", byte_ready, 0);
        check("t4_de", data_enable, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        p0 = pulses;
        for (int i = 0; i < FRAME_BYTES; i++) frm[i] = 8'hFF;
        exp_q.push_back(pack_frame());
        send_frame(0);
        idle(8);
        check("t4_pulses", pulses - p0, 1);
        check("t4_mem3", lm3, 56'hFFFFFFFFFFFFFF);

        // Back-to-back frames
        p0 = pulses;
        r0 = ready_low;
        for (int i = 0; i < FRAME_BYTES; i++) frm[i] = 8'(i * 3);
        exp_q.push_back(pack_frame());
        send_frame(0);
        for (int i = 0; i < FRAME_BYTES; i++) frm[i] = ~8'(i);
        exp_q.push_back(pack_frame());
        send_frame(0);
        byte_valid = 1'b0;
        c1 = 0; c4 = 0;
        repeat (10) begin
            @(negedge clk);
            if (data_enable) c1++;
            if (b_de) c4++;
        end
        check("t5_pulses", pulses - p0, 2);
        check("t5_ready_low", ready_low - r0, 2);
        check("t5_de1_cycles", c1, 1);
        check("t5_de4_cycles", c4, 4);
        check("t5_mem6", lm6, 56'hDCDBDAD9D8D7D6);

`ifdef PATTERN_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            for (int i = 0; i < FRAME_BYTES; i++) frm[i] = 8'(i);
            p0 = pulses;
            exp_q.push_back(pack_frame());
            send_frame(0);
            idle(8);
            check("c1_pulses", pulses - p0, 1);
            check("c1_err", frame_error, 0);
            for (int i = 0; i < FRAME_BYTES; i++) frm[i] = 8'(i + 1);
            x = '0;
            p0 = pulses;
            for (int b = 0; b < FRAME_BYTES; b++) begin
                send_byte(frm[b], b == 0);
                x ^= frm[b];
            end
            check("c2_state_check", st, ST_CHECK);
            send_byte(x ^ 8'hFF, 1'b0);
            check("c2_err", frame_error, 1);
            byte_valid = 1'b0;
            @(negedge clk);
            check("c2_err_off", frame_error, 0);
            idle(6);
            check("c2_pulses", pulses - p0, 0);
            check("c2_mem1", lm1, 56'h00010203040506);
        end
`endif

        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
